// File: rtl/ddr3_app_pkg.sv
// Shared definitions for the DDR3 app-interface arbiter: command encodings and FSM states.
package ddr3_app_pkg;

    localparam logic [2:0] CMD_WRITE = 3'd0;
    localparam logic [2:0] CMD_READ  = 3'd1;
    localparam int         NUM_REQ   = 2;

    typedef enum logic [1:0] {
        WAIT_CAL = 2'd0,
        ARB      = 2'd1,
        ISSUE    = 2'd2
    } arb_state_t;

endpackage

// File: rtl/ddr3_tag_fifo.sv
// In-order 1-bit tag FIFO remembering which requester issued each outstanding read.
module ddr3_tag_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     push_tag,
    input  logic                     pop,
    output logic                     pop_tag,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0]   mem_reg;
    logic [PW-1:0]      wr_ptr_reg;
    logic [PW-1:0]      rd_ptr_reg;
    logic [PW:0]        count_reg;
    logic [PW:0]        count_next;
    logic               do_push;
    logic               do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (PW+1)'(DEPTH));
    assign count   = count_reg;
    assign pop_tag = mem_reg[rd_ptr_reg];
    assign do_pop  = pop & ~empty;
    // A full FIFO can still take a push when a pop frees the slot in the same cycle.
    assign do_push = push & (~full | do_pop);

    always_comb begin
        count_next = count_reg;
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/ddr3_app_arbiter.sv
// Round-robin two-requester sequencer in front of the DDR3 controller app interface,
// with in-order routing of read returns back to the issuing requester.
module ddr3_app_arbiter
    import ddr3_app_pkg::*;
#(
    parameter int ADDR_W    = 29,
    parameter int DATA_W    = 256,
    parameter int MASK_W    = 32,
    parameter int TAG_DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     init_calib_complete,
    input  logic                     m0_en,
    input  logic [2:0]               m0_cmd,
    input  logic [ADDR_W-1:0]        m0_addr,
    input  logic [DATA_W-1:0]        m0_wdf_data,
    input  logic [MASK_W-1:0]        m0_wdf_mask,
    output logic                     m0_rdy,
    output logic                     m0_rd_valid,
    output logic [DATA_W-1:0]        m0_rd_data,
    input  logic                     m1_en,
    input  logic [2:0]               m1_cmd,
    input  logic [ADDR_W-1:0]        m1_addr,
    input  logic [DATA_W-1:0]        m1_wdf_data,
    input  logic [MASK_W-1:0]        m1_wdf_mask,
    output logic                     m1_rdy,
    output logic                     m1_rd_valid,
    output logic [DATA_W-1:0]        m1_rd_data,
    input  logic                     app_rdy,
    input  logic                     wr_data_rdy,
    output logic                     app_en,
    output logic [2:0]               app_cmd,
    output logic [ADDR_W-1:0]        app_addr,
    output logic                     app_wdf_wren,
    output logic                     app_wdf_end,
    output logic [DATA_W-1:0]        app_wdf_data,
    output logic [MASK_W-1:0]        app_wdf_mask,
    output logic                     app_burst,
    input  logic                     app_rd_data_valid,
    input  logic [DATA_W-1:0]        app_rd_data,
    output logic [$clog2(TAG_DEPTH):0] rd_outstanding,
    output logic                     err_orphan,
    output logic [1:0]               arb_state
);
    arb_state_t          state_reg;
    logic                rr_reg;
    logic                app_en_reg;
    logic [2:0]          app_cmd_reg;
    logic [ADDR_W-1:0]   app_addr_reg;
    logic                wren_reg;
    logic [DATA_W-1:0]   wdf_data_reg;
    logic [MASK_W-1:0]   wdf_mask_reg;
    logic                err_orphan_reg;

    logic [NUM_REQ-1:0]  req_en;
    logic [2:0]          req_cmd  [NUM_REQ];
    logic [ADDR_W-1:0]   req_addr [NUM_REQ];
    logic [DATA_W-1:0]   req_data [NUM_REQ];
    logic [MASK_W-1:0]   req_mask [NUM_REQ];
    logic [NUM_REQ-1:0]  eligible;
    logic [NUM_REQ-1:0]  rd_valid_reg;
    logic [DATA_W-1:0]   rd_data_reg [NUM_REQ];

    logic                gnt_any;
    logic                gnt_idx;
    logic                tag_full;
    logic                tag_empty;
    logic                tag_out;
    logic                tag_push;

    assign req_en      = {m1_en, m0_en};
    assign req_cmd[0]  = m0_cmd;
    assign req_cmd[1]  = m1_cmd;
    assign req_addr[0] = m0_addr;
    assign req_addr[1] = m1_addr;
    assign req_data[0] = m0_wdf_data;
    assign req_data[1] = m1_wdf_data;
    assign req_mask[0] = m0_wdf_mask;
    assign req_mask[1] = m1_wdf_mask;

    // A read may only be granted while a tag slot is free.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_elig
            assign eligible[gi] = req_en[gi] & ((req_cmd[gi] != CMD_READ) | ~tag_full);
        end
    endgenerate

    assign gnt_any  = (state_reg == ARB) & (|eligible);
    assign gnt_idx  = (&eligible) ? rr_reg : eligible[1];
    assign m0_rdy   = gnt_any & ~gnt_idx;
    assign m1_rdy   = gnt_any &  gnt_idx;
    assign tag_push = gnt_any & (req_cmd[gnt_idx] == CMD_READ);

    ddr3_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (tag_push),
        .push_tag (gnt_idx),
        .pop      (app_rd_data_valid),
        .pop_tag  (tag_out),
        .full     (tag_full),
        .empty    (tag_empty),
        .count    (rd_outstanding)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= WAIT_CAL;
            rr_reg       <= 1'b0;
            app_en_reg   <= 1'b0;
            app_cmd_reg  <= '0;
            app_addr_reg <= '0;
            wren_reg     <= 1'b0;
            wdf_data_reg <= '0;
            wdf_mask_reg <= '0;
        end else begin
            case (state_reg)
                WAIT_CAL: begin
                    if (init_calib_complete) state_reg <= ARB;
                end
                ARB: begin
                    if (gnt_any) begin
                        rr_reg       <= ~gnt_idx;
                        app_en_reg   <= 1'b1;
                        app_cmd_reg  <= req_cmd[gnt_idx];
                        app_addr_reg <= req_addr[gnt_idx];
                        if (req_cmd[gnt_idx] == CMD_WRITE) begin
                            wren_reg     <= 1'b1;
                            wdf_data_reg <= req_data[gnt_idx];
                            wdf_mask_reg <= req_mask[gnt_idx];
                        end
                        state_reg <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (app_en_reg & app_rdy)      app_en_reg <= 1'b0;
                    if (wren_reg & wr_data_rdy)    wren_reg   <= 1'b0;
                    // Leave once neither handshake will still be pending next cycle.
                    if (!(app_en_reg & ~app_rdy) && !(wren_reg & ~wr_data_rdy))
                        state_reg <= ARB;
                end
                default: state_reg <= WAIT_CAL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_orphan_reg <= 1'b0;
        end else if (app_rd_data_valid & tag_empty) begin
            err_orphan_reg <= 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rd
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_valid_reg[gi] <= 1'b0;
                    rd_data_reg[gi]  <= '0;
                end else begin
                    rd_valid_reg[gi] <= app_rd_data_valid & ~tag_empty & (tag_out == 1'(gi));
                    if (app_rd_data_valid & ~tag_empty & (tag_out == 1'(gi)))
                        rd_data_reg[gi] <= app_rd_data;
                end
            end
        end
    endgenerate

    assign m0_rd_valid  = rd_valid_reg[0];
    assign m1_rd_valid  = rd_valid_reg[1];
    assign m0_rd_data   = rd_data_reg[0];
    assign m1_rd_data   = rd_data_reg[1];
    assign app_en       = app_en_reg;
    assign app_cmd      = app_cmd_reg;
    assign app_addr     = app_addr_reg;
    assign app_wdf_wren = wren_reg;
    assign app_wdf_end  = wren_reg;
    assign app_wdf_data = wdf_data_reg;
    assign app_wdf_mask = wdf_mask_reg;
    assign app_burst    = 1'b0;
    assign err_orphan   = err_orphan_reg;
    assign arb_state    = state_reg;

endmodule
